bench_vector_harness: RTL and testbench

//   Clocked, parametrised test harness for combinational benchmark cores (ISCAS-class, e.g. 41-in/32-out).

---
 rtl/bench_vector_harness_if.sv | 28 ++
 rtl/bench_vector_harness.sv | 156 +++++++++++++++
 tb/tb_bench_vector_harness.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bench_vector_harness_if.sv
// Vector/result bus of the benchmark harness.
// Carries the vector-offer channel (valid/ready, data, expected response)
// and the result channel (valid/ready, captured data, mismatch flag).
//   master : vector source / result consumer (test bench or pattern store)
//   slave  : the harness itself
interface bench_vector_harness_if #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 32
);
  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  vec_data;
  logic [OUT_W-1:0] vec_exp;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic             res_mismatch;

  modport master (
    output vec_valid, vec_data, vec_exp, res_ready,
    input  vec_ready, res_valid, res_data, res_mismatch
  );

  modport slave (
    input  vec_valid, vec_data, vec_exp, res_ready,
    output vec_ready, res_valid, res_data, res_mismatch
  );
endinterface

// File: rtl/bench_vector_harness.sv
// Clocked harness for a combinational benchmark core.
// Applies one vector at a time to the core, waits SETTLE_CYC extra cycles,
// captures the core response, compares it with the expected value under
// CMP_MASK and keeps saturating result/mismatch counters.
//
// Optional feature: define BENCH_HARNESS_MISR_EN to compact every handed-off
// result into a MISR signature; otherwise o_signature is tied to zero.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i_clr       : synchronous clear of counters and signature
//   bus         : vector/result handshake bus (slave side)
//   o_dut_in    : registered drive to the core inputs
//   i_dut_out   : combinational core outputs
//   o_vec_cnt   : results handed off (saturating)
//   o_mism_cnt  : mismatching results handed off (saturating)
//   o_signature : MISR value (0 when the MISR is not built)
module bench_vector_harness #(
  parameter int               IN_W       = 41,
  parameter int               OUT_W      = 32,
  parameter int               SETTLE_CYC = 2,
  parameter int               CNT_W      = 16,
  parameter logic [OUT_W-1:0] CMP_MASK   = {OUT_W{1'b1}},
  parameter logic [31:0]      MISR_POLY  = 32'h04C11DB7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  bench_vector_harness_if.slave  bus,
  output logic [IN_W-1:0]        o_dut_in,
  input  logic [OUT_W-1:0]       i_dut_out,
  output logic [CNT_W-1:0]       o_vec_cnt,
  output logic [CNT_W-1:0]       o_mism_cnt,
  output logic [OUT_W-1:0]       o_signature
);

  localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [OUT_W-1:0] POLY = OUT_W'(MISR_POLY);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_dut_in;
  logic [OUT_W-1:0] r_exp;
  logic [SW-1:0]    r_wait;
  logic [OUT_W-1:0] r_res_data;
  logic             r_res_valid;
  logic             r_res_mismatch;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_mism_cnt;

  logic w_vec_ready;
  logic w_accept;
  logic w_res_hs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
    return ((s << 1) ^ (s[OUT_W-1] ? POLY : {OUT_W{1'b0}})) ^ d;
  endfunction

  // A new vector can be taken when idle, or while handing off the previous
  // result so back-to-back vectors lose no cycle.
  assign w_vec_ready = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.res_ready);
  assign w_accept    = bus.vec_valid & w_vec_ready;
  assign w_res_hs    = r_res_valid & bus.res_ready;

  assign bus.vec_ready    = w_vec_ready;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_mismatch = r_res_mismatch;
  assign o_dut_in         = r_dut_in;
  assign o_vec_cnt        = r_vec_cnt;
  assign o_mism_cnt       = r_mism_cnt;

  // ---- stage: vector apply / settle / capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_dut_in       <= '0;
      r_exp          <= '0;
      r_wait         <= '0;
      r_res_data     <= '0;
      r_res_valid    <= 1'b0;
      r_res_mismatch <= 1'b0;
    end else begin
      // dut_in only moves on accept so the core never sees spurious toggles.
      if (w_accept) begin
        r_dut_in <= bus.vec_data;
        r_exp    <= bus.vec_exp;
        r_wait   <= SW'(SETTLE_CYC);
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - SW'(1);
          end else begin
            r_res_data     <= i_dut_out;
            r_res_mismatch <= |((i_dut_out ^ r_exp) & CMP_MASK);
            r_res_valid    <= 1'b1;
            r_state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= bus.vec_valid ? S_SETTLE : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- stage: result bookkeeping (clear beats a coincident handoff) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt  <= '0;
      r_mism_cnt <= '0;
    end else if (i_clr) begin
      r_vec_cnt  <= '0;
      r_mism_cnt <= '0;
    end else if (w_res_hs) begin
      r_vec_cnt  <= sat_inc(r_vec_cnt, 1'b1);
      r_mism_cnt <= sat_inc(r_mism_cnt, r_res_mismatch);
    end
  end

`ifdef BENCH_HARNESS_MISR_EN
  logic [OUT_W-1:0] r_signature;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signature <= '0;
    end else if (i_clr) begin
      r_signature <= '0;
    end else if (w_res_hs) begin
      r_signature <= misr_step(r_signature, r_res_data);
    end
  end

  assign o_signature = r_signature;
`else
  assign o_signature = '0;
`endif

endmodule

// File: tb/tb_bench_vector_harness.sv
module tb_bench_vector_harness;

  localparam int IN_W   = 41;
  localparam int OUT_W  = 32;
  localparam int SETTLE = 2;
`ifdef BENCH_HARNESS_MISR_EN
  localparam bit MISR = 1'b1;
`else
  localparam bit MISR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             tb_clr = 1'b0;
  logic             tb_vec_valid = 1'b0;
  logic [IN_W-1:0]  tb_vec_data = '0;
  logic [OUT_W-1:0] tb_vec_exp = '0;
  logic             tb_res_ready = 1'b0;

  // Reference combinational core used as the device under harness.
  function automatic logic [OUT_W-1:0] core_fn(input logic [IN_W-1:0] x);
    return x[31:0] ^ {x[40:32], x[40:18]};
  endfunction

  // Instance 0: default parameters. Instance 1: 2-bit counters, mask all-zero.
  bench_vector_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus0 ();
  bench_vector_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();

  assign bus0.vec_valid = tb_vec_valid;
  assign bus0.vec_data  = tb_vec_data;
  assign bus0.vec_exp   = tb_vec_exp;
  assign bus0.res_ready = tb_res_ready;
  assign bus1.vec_valid = tb_vec_valid;
  assign bus1.vec_data  = tb_vec_data;
  assign bus1.vec_exp   = tb_vec_exp;
  assign bus1.res_ready = tb_res_ready;

  logic [IN_W-1:0]  din0, din1;
  logic [OUT_W-1:0] dout0, dout1, sig0, sig1;
  logic [15:0]      vcnt0, mcnt0;
  logic [1:0]       vcnt1, mcnt1;

  assign dout0 = core_fn(din0);
  assign dout1 = core_fn(din1);

  bench_vector_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_clr(tb_clr), .bus(bus0),
    .o_dut_in(din0), .i_dut_out(dout0),
    .o_vec_cnt(vcnt0), .o_mism_cnt(mcnt0), .o_signature(sig0)
  );

  bench_vector_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE), .CNT_W(2),
                         .CMP_MASK(32'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_clr(tb_clr), .bus(bus1),
    .o_dut_in(din1), .i_dut_out(dout1),
    .o_vec_cnt(vcnt1), .o_mism_cnt(mcnt1), .o_signature(sig1)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding vector with its accept time.
  int               cyc = 0;
  bit               m_busy = 1'b0;
  int               m_acc_cyc = 0;
  logic [IN_W-1:0]  m_vec = '0;
  logic [OUT_W-1:0] m_exp = '0;
  logic [IN_W-1:0]  m_din = '0;
  int               m_cnt0 = 0, m_mis0 = 0, m_cnt1 = 0;
  logic [OUT_W-1:0] m_sig = '0;

  function automatic bit m_rv();
    return m_busy && ((cyc - m_acc_cyc) >= SETTLE + 1);
  endfunction

  function automatic bit m_mm();
    return ((core_fn(m_vec) ^ m_exp) != '0);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_vec = '0; m_exp = '0; m_din = '0;
    m_cnt0 = 0; m_mis0 = 0; m_cnt1 = 0; m_sig = '0;
  endtask

  task automatic check_outputs(input bit rr);
    bit rdy;
    rdy = !m_busy || (m_rv() && rr);
    chk("vec_ready0", bus0.vec_ready, rdy);
    chk("vec_ready1", bus1.vec_ready, rdy);
    chk("res_valid0", bus0.res_valid, m_rv());
    chk("res_valid1", bus1.res_valid, m_rv());
    chk("dut_in0", din0, m_din);
    chk("dut_in1", din1, m_din);
    chk("vec_cnt0", vcnt0, m_cnt0);
    chk("mism_cnt0", mcnt0, m_mis0);
    chk("vec_cnt1", vcnt1, m_cnt1);
    chk("mism_cnt1", mcnt1, 0);
    chk("signature0", sig0, m_sig);
    chk("signature1", sig1, MISR ? m_sig : '0);
    if (m_rv()) begin
      chk("res_data0", bus0.res_data, core_fn(m_vec));
      chk("res_data1", bus1.res_data, core_fn(m_vec));
      chk("res_mism0", bus0.res_mismatch, m_mm());
      chk("res_mism1", bus1.res_mismatch, 1'b0);
    end
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input bit vv, input logic [IN_W-1:0] d, input logic [OUT_W-1:0] e,
                      input bit rr, input bit cl);
    bit acc, hs, mm;
    logic [OUT_W-1:0] rd;
    tb_vec_valid = vv; tb_vec_data = d; tb_vec_exp = e; tb_res_ready = rr; tb_clr = cl;
    #1;
    check_outputs(rr);
    hs  = m_rv() && rr;
    acc = vv && (!m_busy || hs);
    mm  = m_mm();
    rd  = core_fn(m_vec);
    @(posedge clk);
    cyc++;
    if (hs) begin
      m_busy = 1'b0;
      if (!cl) begin
        m_cnt0 = (m_cnt0 == 65535) ? 65535 : m_cnt0 + 1;
        m_mis0 = (mm && m_mis0 != 65535) ? m_mis0 + 1 : m_mis0;
        m_cnt1 = (m_cnt1 == 3) ? 3 : m_cnt1 + 1;
        if (MISR) m_sig = ((m_sig << 1) ^ (m_sig[31] ? 32'h04C11DB7 : 32'h0)) ^ rd;
      end
    end
    if (cl) begin
      m_cnt0 = 0; m_mis0 = 0; m_cnt1 = 0; m_sig = '0;
    end
    if (acc) begin
      m_busy = 1'b1; m_acc_cyc = cyc; m_vec = d; m_exp = e; m_din = d;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic handoff(input bit cl);
    step(1'b0, '0, '0, 1'b1, cl);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock.
  task automatic async_reset();
    tb_vec_valid = 1'b0; tb_res_ready = 1'b0; tb_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_res_data0", bus0.res_data, 0);
    chk("rst_res_mism0", bus0.res_mismatch, 0);
    chk("rst_res_data1", bus1.res_data, 0);
    check_outputs(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [IN_W-1:0]  d;
    logic [OUT_W-1:0] e;
    bit vv, rr, cl;

    @(negedge clk);
    async_reset();

    // Zero vector with matching expectation: latency and clean compare.
    step(1'b1, '0, core_fn('0), 1'b0, 1'b0);
    idle_cycles(4);
    handoff(1'b0);
    chk("cnt_after_first", vcnt0, 1);

    // Inverted expectation forces a mismatch on every bit.
    d = 41'h1_2345_6789A;
    step(1'b1, d, ~core_fn(d), 1'b0, 1'b0);
    idle_cycles(3);
    handoff(1'b0);
    chk("mism_after_inv", mcnt0, 1);

    // Long stall with the next vector waiting, then same-cycle accept.
    d = 41'h0_AAAA_5555A;
    step(1'b1, d, core_fn(d), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 41'h1_FFFF_0000F, 32'h0, 1'b0, 1'b0);
    step(1'b1, 41'h1_FFFF_0000F, 32'h0, 1'b1, 1'b0);
    chk("chain_busy", din0, 41'h1_FFFF_0000F);
    idle_cycles(3);
    handoff(1'b0);

    // Signature sequence from a cleared start: results 0x1 then 0x0.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 41'h1, 32'h1, 1'b0, 1'b0);
    idle_cycles(3);
    handoff(1'b0);
    chk("sig_seq1", sig0, MISR ? 32'h1 : 32'h0);
    step(1'b1, 41'h0, 32'h0, 1'b0, 1'b0);
    idle_cycles(3);
    handoff(1'b0);
    chk("sig_seq2", sig0, MISR ? 32'h2 : 32'h0);

    // Drive the 2-bit counters into saturation, then clear on a handoff.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, IN_W'(k), 32'h0, 1'b0, 1'b0);
      idle_cycles(3);
      handoff(1'b0);
    end
    chk("sat_vec_cnt1", vcnt1, 3);
    step(1'b1, 41'h5, 32'h0, 1'b0, 1'b0);
    idle_cycles(3);
    handoff(1'b1);
    chk("clr_hs_vec0", vcnt0, 0);
    chk("clr_hs_mism0", mcnt0, 0);
    chk("clr_hs_vec1", vcnt1, 0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) async_reset();
      vv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 24) == 0);
      d  = ($urandom_range(0, 7) == 0) ? '0 : IN_W'({$urandom(), $urandom()});
      case ($urandom_range(0, 2))
        0:       e = core_fn(d);
        1:       e = ~core_fn(d);
        default: e = $urandom();
      endcase
      step(vv, d, e, rr, cl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
